// File: rtl/spi_regbank.sv
// spi_regbank: SPI (mode 0) slave that fills a bank of NUM_REGS registers of
// DATA_W bits. A frame is 1 + ADDR_W + DATA_W bits, MSB first: R/W (1 = write),
// address, data. sclk/ncs/copi are synchronised into clk; all logic on clk.
// Optional macro SPI_READBACK_EN: read frames return register[addr] on cipo.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sclk, ncs, copi SPI inputs (asynchronous to clk)
//   cipo            SPI data out, 0 while ncs is high
//   regs_flat       all registers, register i at [i*DATA_W +: DATA_W]
//   wr_strobe       one-cycle pulse per committed write, with wr_addr
//   frame_err       one-cycle pulse per aborted or over-length frame
module spi_regbank #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  logic [2:0]           sclk_q, ncs_q;
  logic [1:0]           copi_q;
  logic [1:0]           settle_q;
  logic                 armed_q;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d, sr_shift;
  logic                 ov_q, ov_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic                 wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic                 frame_err_q, frame_err_d;

  logic                 sclk_rise, ncs_rise, ncs_fall;
  logic                 f_rw;
  logic [ADDR_W-1:0]    f_addr;
  logic [DATA_W-1:0]    f_data;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
  assign sr_shift  = {sr_q[FRAME_LEN-2:0], copi_q[1]};
  assign f_rw      = sr_q[FRAME_LEN-1];
  assign f_addr    = sr_q[FRAME_LEN-2 -: ADDR_W];
  assign f_data    = sr_q[DATA_W-1:0];

`ifdef SPI_READBACK_EN
  logic                 sclk_fall;
  logic [DATA_W-1:0]    out_q, out_d, rd_data;
  logic                 cipo_q, cipo_d;
  logic [ADDR_W-1:0]    rd_addr;

  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign rd_addr   = sr_shift[ADDR_W-1:0];
  assign cipo      = cipo_q & ~ncs;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i];
  end
`else
  assign cipo = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    ov_d        = ov_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
`ifdef SPI_READBACK_EN
    out_d  = out_q;
    cipo_d = cipo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ncs_fall && armed_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
          ov_d    = 1'b0;
`ifdef SPI_READBACK_EN
          out_d  = '0;
          cipo_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        // ncs rising edge wins over an sclk edge seen in the same cycle
        if (ncs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = HOLD;
`ifdef SPI_READBACK_EN
          // last address bit just arrived: preload the read data
          if (cnt_q == CNT_W'(ADDR_W) && !sr_shift[ADDR_W]) out_d = rd_data;
`endif
        end
      end
      HOLD: begin
        if (ncs_rise) begin
          state_d = IDLE;
          if (ov_q) begin
            frame_err_d = 1'b1;
          end else if (f_rw && ({1'b0, f_addr} < NREGS)) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
              if (f_addr == ADDR_W'(i)) regs_d[i] = f_data;
            wr_strobe_d = 1'b1;
            wr_addr_d   = f_addr;
          end
        end else if (sclk_rise) begin
          ov_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_READBACK_EN
    if (state_q != IDLE && !ncs_rise && sclk_fall) begin
      cipo_d = out_q[DATA_W-1];
      out_d  = {out_q[DATA_W-2:0], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= '0;
      ncs_q       <= '1;
      copi_q      <= '0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      ov_q        <= 1'b0;
      regs_q      <= '{default: '0};
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
`ifdef SPI_READBACK_EN
      out_q  <= '0;
      cipo_q <= 1'b0;
`endif
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      ncs_q  <= {ncs_q[1:0], ncs};
      copi_q <= {copi_q[0], copi};
      // Arm only once the ncs chain holds real samples and shows ncs high,
      // so a chip select already low at reset release is not taken as a start.
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd3 && ncs_q[2]) armed_q <= 1'b1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ov_q        <= ov_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
`ifdef SPI_READBACK_EN
      out_q  <= out_d;
      cipo_q <= cipo_d;
`endif
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++)
      regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank with default parameters (16-bit frames).
module tb_spi_regbank;

  logic        clk = 1'b0;
  logic        rst, sclk, ncs, copi;
  logic        cipo;
  logic [39:0] regs_flat;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  logic [6:0]  last_addr = '0;
  logic [31:0] rx = '0;
  logic [7:0]  rd_exp;

  spi_regbank #(.ADDR_W(7), .DATA_W(8), .NUM_REGS(5)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      last_addr = wr_addr;
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      #100;
      rx = {rx[30:0], cipo};
      sclk = 1'b1;
      #100;
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    ncs = 1'b0;
    #200;
    send_bits(v, n);
    #100;
    ncs = 1'b1;
    #300;
  endtask

  task automatic clear_counts();
    strobe_cnt = 0;
    err_cnt = 0;
    last_addr = '0;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_regs", regs_flat, 40'h0);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_cipo", cipo, 1'b0);
    check("rst_wraddr", wr_addr, 7'h0);
    rst = 1'b0;
    #200;

    clear_counts();
    frame(32'h82A5, 16);
    check("wr2_regs", regs_flat, 40'h00_00_A5_00_00);
    check("wr2_strobe", strobe_cnt, 1);
    check("wr2_addr", last_addr, 7'h02);
    check("wr2_err", err_cnt, 0);

    clear_counts();
    frame(32'h85FF, 16);
    check("oob_regs", regs_flat, 40'h00_00_A5_00_00);
    check("oob_strobe", strobe_cnt, 0);
    check("oob_err", err_cnt, 0);

    clear_counts();
    frame(32'h8077 >> 6, 10);
    check("abort_regs", regs_flat, 40'h00_00_A5_00_00);
    check("abort_err", err_cnt, 1);
    check("abort_strobe", strobe_cnt, 0);

    clear_counts();
    frame({16'h8111, 1'b1}, 17);
    check("ovl_regs", regs_flat, 40'h00_00_A5_00_00);
    check("ovl_err", err_cnt, 1);

    clear_counts();
    ncs = 1'b0;
    #200;
    send_bits(32'h81, 8);
    rst = 1'b1;
    #50;
    rst = 1'b0;
    send_bits(32'h5, 3);
    #100;
    ncs = 1'b1;
    #300;
    frame(32'h813C, 16);
    check("rstmid_regs", regs_flat, 40'h00_00_00_3C_00);
    check("rstmid_strobe", strobe_cnt, 1);
    check("rstmid_addr", last_addr, 7'h01);
    check("rstmid_err", err_cnt, 0);

    clear_counts();
    frame(32'h845A, 16);
    check("wr4_regs", regs_flat, 40'h5A_00_00_3C_00);
    check("wr4_strobe", strobe_cnt, 1);

    clear_counts();
    rx = '0;
    frame(32'h0400, 16);
`ifdef SPI_READBACK_EN
    rd_exp = 8'h5A;
`else
    rd_exp = 8'h00;
`endif
    check("rd4_data", rx[7:0], rd_exp);
    check("rd4_strobe", strobe_cnt, 0);
    check("rd4_err", err_cnt, 0);
    check("rd4_regs", regs_flat, 40'h5A_00_00_3C_00);
    check("idle_cipo", cipo, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_regbank.md
SPI_REGBANK -- requirements
Module: spi_regbank

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, register data width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 5, number of implemented registers, with range 1..2^ADDR_W.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sclk  input  1  SPI clock, asynchronous to clk, mode 0.
REQ-007 SHALL have port ncs  input  1  SPI chip select, active-low, asynchronous.
REQ-008 SHALL have port copi  input  1  SPI serial data in, MSB first.
REQ-009 SHALL have port cipo  output  1  SPI serial data out; 0 while ncs is high.
REQ-010 SHALL have port regs_flat  output  NUM_REGS*DATA_W  all registers; register i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port wr_strobe  output  1  one-cycle pulse per committed write.
REQ-012 SHALL have port wr_addr  output  ADDR_W  address of the last committed write; valid with wr_strobe.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse per aborted or over-length frame.

Function
REQ-014 SHALL pass sclk, ncs and copi each through 2 flops, then a third flop for edge detect; ncs chain flops reset to 1.
REQ-015 SHALL define FRAME_LEN = 1 + ADDR_W + DATA_W; frame = R/W bit (1 = write), address MSB-first, data MSB-first.
REQ-016 SHALL implement states IDLE, SHIFT, HOLD; IDLE->SHIFT on synced ncs falling edge, clearing bit counter and shift register.
REQ-017 SHALL in SHIFT sample synced copi on each synced sclk rising edge and increment the bit counter; SHIFT->HOLD when count reaches FRAME_LEN.
REQ-018 SHALL in HOLD saturate the counter and set an overlength flag on any further sclk rising edge.
REQ-019 SHALL on synced ncs rising edge in SHIFT (count < FRAME_LEN) discard the frame, pulse frame_err, and go to IDLE.
REQ-020 SHALL on synced ncs rising edge in HOLD with overlength set discard the frame, pulse frame_err, and go to IDLE.
REQ-021 SHALL on synced ncs rising edge in HOLD without overlength, write bit 1 and address < NUM_REGS, update the register and pulse wr_strobe with wr_addr in the same single cycle, then go to IDLE.
REQ-022 SHALL silently ignore writes with address >= NUM_REGS: no update, no wr_strobe, no frame_err.
REQ-023 SHALL give a synced ncs rising edge priority over an sclk edge detected in the same clk cycle; that sclk edge is dropped.
REQ-024 SHALL make wr_strobe and frame_err mutually exclusive and at most one pulse per frame.
REQ-025 SHALL reflect regs_flat updates on the clk edge that asserts wr_strobe; regs_flat is otherwise stable.

Reset
REQ-026 SHALL on rst clear all registers, regs_flat, wr_addr, counters and flags to 0, drive wr_strobe, frame_err and cipo to 0, and set the state to IDLE.
REQ-027 SHALL abandon any frame in flight when rst asserts, without emitting wr_strobe or frame_err for it.
REQ-028 SHALL, if ncs is low when rst deasserts, ignore traffic until a synced ncs rising edge is seen.

Configuration
REQ-029 SHALL, with macro SPI_READBACK_EN defined, answer read frames (R/W bit 0).
REQ-030 SHALL, for such a read, load register[addr] into the out-shifter after the last address bit, or 0 if addr >= NUM_REGS.
REQ-031 SHALL shift the out-shifter onto cipo MSB-first on each subsequent synced sclk falling edge.
REQ-032 SHALL treat a read frame as a no-op at commit: no register change, no wr_strobe; aborts and over-length frames still pulse frame_err.
REQ-033 SHALL, without SPI_READBACK_EN, tie cipo to constant 0, omit the out-shifter, and treat read frames as no-ops with frame_err rules unchanged.

Verification
REQ-034 SHALL cover: defaults, write frame 1,0x02,0xA5 -> regs_flat[23:16]=0xA5, one wr_strobe with wr_addr=2, other bytes 0.
REQ-035 SHALL cover: write to address 0x05 with NUM_REGS=5 -> no change, no wr_strobe, no frame_err.
REQ-036 SHALL cover: ncs raised after 10 bits of a write to addr 0 -> regs unchanged, exactly one frame_err pulse.
REQ-037 SHALL cover: 17 sclk edges on a 16-bit frame -> regs unchanged, frame_err pulse.
REQ-038 SHALL cover: rst asserted mid-frame after 8 bits, then a full write 1,0x01,0x3C -> regs_flat[15:8]=0x3C only, no frame_err.
REQ-039 SHALL cover, with SPI_READBACK_EN: write 0x5A to addr 4, then read addr 4 -> cipo yields 0x5A MSB-first on the data bits; without the macro cipo stays 0.
